// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable width, SCK divider, CPOL/CPHA, bit order
// and chip selects, with a busy/done handshake and a hold half-period after the last edge.
module spi_master_gen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8,
   parameter int NCS    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tx_strobe,
   input  logic              rx_strobe,
   input  logic [DATA_W-1:0] din,
   input  logic [NCS-1:0]    cs_mask,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              busy,
   output logic              spi_clk,
   input  logic              spi_di,
   output logic              spi_do,
   output logic [NCS-1:0]    spi_cs_n
);

   localparam int HP_W = $clog2(2*DATA_W+1);
   localparam logic [HP_W-1:0] LAST_EDGE_HP = HP_W'(2*DATA_W-1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

   state_t              r_state, w_state_nxt;
   logic [DIV_W-1:0]    r_div, r_div_cnt;
   logic [HP_W-1:0]     r_hp;
   logic                r_cpol, r_cpha, r_lsb, r_clk, r_done;
   logic [DATA_W-1:0]   r_tx, r_rx, r_dout;
   logic [NCS-1:0]      r_cs_n;

   logic w_start, w_hp_end, w_edge, w_sample, w_shift, w_finish;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // r_hp indexes the current half-period from 0; edge k ends half-period k-1,
   // so odd edges are those finishing an even r_hp.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_hp_end    = (r_div_cnt == r_div);
      w_edge      = 1'b0;
      w_sample    = 1'b0;
      w_shift     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start = tx_strobe | rx_strobe;
            if (w_start) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            w_edge = w_hp_end;
            if (r_cpha) begin
               w_sample = w_edge & r_hp[0];
               w_shift  = w_edge & ~r_hp[0] & (r_hp != '0);
            end else begin
               w_sample = w_edge & ~r_hp[0];
               w_shift  = w_edge & r_hp[0] & (r_hp != LAST_EDGE_HP);
            end
            if (w_edge && r_hp == LAST_EDGE_HP) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            w_finish = w_hp_end;
            if (w_finish) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div     <= '0;
         r_div_cnt <= '0;
         r_hp      <= '0;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_lsb     <= 1'b0;
         r_clk     <= 1'b0;
         r_done    <= 1'b0;
         r_tx      <= '1;
         r_rx      <= '1;
         r_dout    <= '0;
         r_cs_n    <= '1;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_div     <= clk_div;
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            r_lsb     <= lsb_first;
            r_cs_n    <= ~cs_mask;
            r_tx      <= tx_strobe ? din : '1;
            r_div_cnt <= '0;
            r_hp      <= '0;
            r_clk     <= cpol;
         end else if (r_state == S_IDLE) begin
            r_clk <= cpol;
         end else begin
            if (w_hp_end) begin
               r_div_cnt <= '0;
               r_hp      <= w_finish ? '0 : r_hp + HP_W'(1);
            end else begin
               r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_edge) r_clk <= ~r_clk;
            if (w_sample)
               r_rx <= r_lsb ? {spi_di, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], spi_di};
            if (w_shift)
               r_tx <= r_lsb ? {1'b1, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b1};
            if (w_finish) begin
               r_dout <= r_rx;
               r_cs_n <= '1;
               r_tx   <= '1;
            end
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign dout     = r_dout;
   assign spi_clk  = r_clk;
   assign spi_cs_n = r_cs_n;
   assign spi_do   = r_lsb ? r_tx[0] : r_tx[DATA_W-1];

endmodule
